// File: rtl/audio_viz_feeder_if.sv
// Sample stream from the audio FIFO into the feeder.
// Valid/ready handshake carrying 8-bit unsigned samples centred on 128.
interface audio_viz_feeder_if;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_ready;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/audio_viz_feeder.sv
// Paces samples from the audio FIFO into the audio_viz datapath and turns its
// thermometer output into a peak-hold/decay level with a clip interrupt.
module audio_viz_feeder #(
    parameter int DIV_W      = 16,
    parameter int HOLD_TICKS = 4800,
    parameter int UNDERRUN_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [DIV_W-1:0]      divisor,
    audio_viz_feeder_if.slave     s,
    output logic [7:0]            audio_out,
    input  logic [7:0]            viz_in,
    output logic [7:0]            peak_out,
    output logic                  irq_clip,
    output logic [UNDERRUN_W-1:0] underrun_cnt,
    output logic                  busy
);

    localparam int                HOLD_W    = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_TICKS - 1);
    localparam logic [7:0]        SILENCE   = 8'd128;

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        RUN
    } state_t;

    state_t            state;
    logic [DIV_W-1:0]  tick_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic              peak_msb_q;
    logic              tick;
    logic [7:0]        peak_new_bars;

    assign tick          = (state == RUN) && (tick_cnt == '0);
    // NOTE: s_ready is decoded from registered state so the FIFO sees it in the tick cycle itself.
    assign s.s_ready     = tick;
    assign busy          = (state != IDLE);
    assign peak_new_bars = viz_in & ~peak_out;

    // NOTE: every register here uses <=; a later assignment in the same edge overrides an earlier one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            tick_cnt     <= '0;
            hold_cnt     <= '0;
            audio_out    <= SILENCE;
            peak_out     <= '0;
            peak_msb_q   <= 1'b0;
            irq_clip     <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            peak_msb_q <= peak_out[7];
            irq_clip   <= peak_out[7] & ~peak_msb_q;

            // A tick is honoured even when enable drops in the same cycle.
            if (tick) begin
                if (s.s_valid) begin
                    audio_out <= s.s_data;
                end else begin
                    audio_out <= SILENCE;
                    if (underrun_cnt != '1) begin
                        underrun_cnt <= underrun_cnt + 1'b1;
                    end
                end

                if (peak_new_bars != 8'h00) begin
                    peak_out <= peak_out | viz_in;
                    hold_cnt <= HOLD_LOAD;
                end else if (hold_cnt == '0) begin
                    if (peak_out != 8'h00) begin
                        peak_out <= peak_out >> 1;
                        hold_cnt <= HOLD_LOAD;
                    end
                end else begin
                    hold_cnt <= hold_cnt - 1'b1;
                end
            end

            if (!enable) begin
                state <= IDLE;
                if (!tick) begin
                    audio_out <= SILENCE;
                end
            end else begin
                case (state)
                    IDLE: begin
                        state        <= PRIME;
                        audio_out    <= SILENCE;
                        peak_out     <= '0;
                        underrun_cnt <= '0;
                        hold_cnt     <= '0;
                        tick_cnt     <= '0;
                    end
                    PRIME: begin
                        if (s.s_valid) begin
                            state    <= RUN;
                            tick_cnt <= '0;
                        end
                    end
                    RUN: begin
                        // The divisor is only looked at on reload, so a change waits for the period to end.
                        tick_cnt <= tick ? divisor : tick_cnt - 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_audio_viz_feeder.sv
// Self-checking bench for audio_viz_feeder: randomized streams and peak levels
// checked against a tick-level behavioural model of the pacing and peak rules.
module tb_audio_viz_feeder;

    localparam int HOLD = 4;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [15:0] divisor;
    logic [7:0]  audio_out;
    logic [7:0]  viz_in;
    logic [7:0]  peak_out;
    logic        irq_clip;
    logic [3:0]  underrun_cnt;
    logic        busy;

    int passed = 0;
    int total  = 0;

    audio_viz_feeder_if sif ();

    audio_viz_feeder #(
        .DIV_W     (16),
        .HOLD_TICKS(HOLD),
        .UNDERRUN_W(4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .divisor     (divisor),
        .s           (sif),
        .audio_out   (audio_out),
        .viz_in      (viz_in),
        .peak_out    (peak_out),
        .irq_clip    (irq_clip),
        .underrun_cnt(underrun_cnt),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got still running, want finished");
        $fatal(1);
    end

    task automatic go_idle();
        enable      = 1'b0;
        sif.s_valid = 1'b0;
        viz_in      = 8'h00;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        #1;
        total++; if (audio_out !== 8'd128) $display("FAIL reset_audio: got %0h want 80", audio_out); else passed++;
        total++; if (sif.s_ready !== 1'b0) $display("FAIL reset_ready: got %0b want 0", sif.s_ready); else passed++;
        total++; if (peak_out !== 8'h00) $display("FAIL reset_peak: got %0h want 0", peak_out); else passed++;
        total++; if (irq_clip !== 1'b0) $display("FAIL reset_irq: got %0b want 0", irq_clip); else passed++;
        total++; if (underrun_cnt !== 4'd0) $display("FAIL reset_under: got %0d want 0", underrun_cnt); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", busy); else passed++;
        @(negedge clk);
        rst         = 1'b1;
        sif.s_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            total++; if (busy !== 1'b0 || sif.s_ready !== 1'b0) $display("FAIL idle_no_enable: got busy=%0b ready=%0b want 0 0", busy, sif.s_ready); else passed++;
        end
        sif.s_valid = 1'b0;
    endtask

    task automatic test_stream_div3();
        logic [7:0] exp_audio;
        int k;
        go_idle();
        divisor = 16'd3;
        enable  = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            total++; if (busy !== 1'b1 || sif.s_ready !== 1'b0 || underrun_cnt !== 4'd0) $display("FAIL prime_wait: got busy=%0b ready=%0b under=%0d want 1 0 0", busy, sif.s_ready, underrun_cnt); else passed++;
            @(negedge clk);
        end
        sif.s_valid = 1'b1;
        sif.s_data  = 8'h10;
        @(negedge clk);
        exp_audio = 8'd128;
        k = 0;
        for (int c = 0; c < 32; c++) begin
            total++; if (sif.s_ready !== ((c % 4) == 0)) $display("FAIL div3_ready c=%0d: got %0b want %0b", c, sif.s_ready, (c % 4) == 0); else passed++;
            total++; if (audio_out !== exp_audio) $display("FAIL div3_audio c=%0d: got %0h want %0h", c, audio_out, exp_audio); else passed++;
            sif.s_data = 8'((k + 1) * 16);
            if ((c % 4) == 0) begin
                exp_audio = sif.s_data;
                k++;
            end
            @(negedge clk);
        end
        total++; if (underrun_cnt !== 4'd0) $display("FAIL div3_under: got %0d want 0", underrun_cnt); else passed++;
    endtask

    task automatic test_random_stream();
        logic [7:0] exp_audio;
        int exp_under;
        int next_tick;
        go_idle();
        divisor = 16'($urandom_range(0, 4));
        enable  = 1'b1;
        @(negedge clk);
        sif.s_valid = 1'b1;
        @(negedge clk);
        exp_audio = 8'd128;
        exp_under = 0;
        next_tick = 0;
        for (int c = 0; c < 200; c++) begin
            total++; if (sif.s_ready !== (c == next_tick)) $display("FAIL rand_ready c=%0d: got %0b want %0b", c, sif.s_ready, c == next_tick); else passed++;
            total++; if (audio_out !== exp_audio) $display("FAIL rand_audio c=%0d: got %0h want %0h", c, audio_out, exp_audio); else passed++;
            total++; if (underrun_cnt !== 4'(exp_under)) $display("FAIL rand_under c=%0d: got %0d want %0d", c, underrun_cnt, exp_under); else passed++;
            sif.s_valid = ($urandom_range(0, 3) != 0);
            sif.s_data  = 8'($urandom);
            if (c == next_tick) begin
                if (sif.s_valid) begin
                    exp_audio = sif.s_data;
                end else begin
                    exp_audio = 8'd128;
                    if (exp_under < 15) exp_under++;
                end
                next_tick = c + int'(divisor) + 1;
            end
            @(negedge clk);
            if ($urandom_range(0, 19) == 0) divisor = 16'($urandom_range(0, 4));
        end
    endtask

    task automatic test_underrun_gap();
        logic [7:0] samples [16];
        logic [7:0] exp_audio;
        int idx;
        bit v;
        for (int i = 0; i < 16; i++) samples[i] = 8'($urandom_range(0, 127));
        go_idle();
        divisor = 16'd0;
        enable  = 1'b1;
        @(negedge clk);
        sif.s_valid = 1'b1;
        @(negedge clk);
        exp_audio = 8'd128;
        idx = 0;
        for (int c = 0; c < 18; c++) begin
            total++; if (sif.s_ready !== 1'b1) $display("FAIL gap_ready c=%0d: got %0b want 1", c, sif.s_ready); else passed++;
            total++; if (audio_out !== exp_audio) $display("FAIL gap_audio c=%0d: got %0h want %0h", c, audio_out, exp_audio); else passed++;
            v = !(c >= 4 && c < 9);
            sif.s_valid = v;
            sif.s_data  = v ? samples[idx] : 8'($urandom_range(200, 255));
            if (v) begin
                exp_audio = samples[idx];
                idx++;
            end else begin
                exp_audio = 8'd128;
            end
            @(negedge clk);
        end
        total++; if (audio_out !== exp_audio) $display("FAIL gap_last: got %0h want %0h", audio_out, exp_audio); else passed++;
        total++; if (underrun_cnt !== 4'd5) $display("FAIL gap_under: got %0d want 5", underrun_cnt); else passed++;
    endtask

    task automatic test_underrun_saturate();
        go_idle();
        divisor = 16'd0;
        enable  = 1'b1;
        @(negedge clk);
        sif.s_valid = 1'b1;
        @(negedge clk);
        for (int c = 0; c < 22; c++) begin
            total++; if (underrun_cnt !== 4'((c < 15) ? c : 15)) $display("FAIL sat_under c=%0d: got %0d want %0d", c, underrun_cnt, (c < 15) ? c : 15); else passed++;
            if (c > 0) begin
                total++; if (audio_out !== 8'd128) $display("FAIL sat_audio c=%0d: got %0h want 80", c, audio_out); else passed++;
            end
            sif.s_valid = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_peak_hold();
        logic [7:0] exp_peak;
        go_idle();
        divisor = 16'd0;
        viz_in  = 8'hFF;
        enable  = 1'b1;
        @(negedge clk);
        sif.s_valid = 1'b1;
        sif.s_data  = 8'h40;
        @(negedge clk);
        for (int j = 0; j < 40; j++) begin
            exp_peak = (j == 0) ? 8'h00 : 8'(255 >> ((j - 1) / HOLD));
            total++; if (peak_out !== exp_peak) $display("FAIL peak_decay j=%0d: got %0h want %0h", j, peak_out, exp_peak); else passed++;
            total++; if (irq_clip !== (j == 2)) $display("FAIL peak_irq j=%0d: got %0b want %0b", j, irq_clip, j == 2); else passed++;
            viz_in = (j == 0) ? 8'hFF : 8'h00;
            @(negedge clk);
        end
    endtask

    task automatic test_peak_random();
        logic [7:0] p, vis1, vis2, v;
        int h;
        int n;
        go_idle();
        divisor = 16'd1;
        enable  = 1'b1;
        @(negedge clk);
        sif.s_valid = 1'b1;
        @(negedge clk);
        p = 8'h00; vis1 = 8'h00; vis2 = 8'h00; h = 0;
        for (int c = 0; c < 300; c++) begin
            total++; if (peak_out !== p) $display("FAIL peak_rand c=%0d: got %0h want %0h", c, peak_out, p); else passed++;
            total++; if (irq_clip !== (vis1[7] & ~vis2[7])) $display("FAIL irq_rand c=%0d: got %0b want %0b", c, irq_clip, vis1[7] & ~vis2[7]); else passed++;
            vis2 = vis1;
            vis1 = p;
            if ($urandom_range(0, 4) == 0) begin
                n = $urandom_range(1, 8);
                v = 8'((1 << n) - 1);
            end else begin
                v = 8'h00;
            end
            viz_in = v;
            if ((c % 2) == 0) begin
                if ((v & ~p) != 8'h00) begin
                    p = p | v;
                    h = HOLD - 1;
                end else if (h == 0) begin
                    if (p != 8'h00) begin
                        p = p >> 1;
                        h = HOLD - 1;
                    end
                end else begin
                    h = h - 1;
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_enable_drop();
        go_idle();
        divisor = 16'd2;
        enable  = 1'b1;
        @(negedge clk);
        sif.s_valid = 1'b1;
        sif.s_data  = 8'h11;
        viz_in      = 8'h0F;
        @(negedge clk);
        for (int c = 0; c < 4; c++) begin
            total++; if (sif.s_ready !== (c == 0 || c == 3)) $display("FAIL drop_ready c=%0d: got %0b want %0b", c, sif.s_ready, c == 0 || c == 3); else passed++;
            if (c == 0) sif.s_valid = 1'b0;
            if (c == 3) begin
                sif.s_valid = 1'b1;
                sif.s_data  = 8'hAB;
                enable      = 1'b0;
            end
            @(negedge clk);
        end
        total++; if (busy !== 1'b0 || sif.s_ready !== 1'b0) $display("FAIL drop_idle: got busy=%0b ready=%0b want 0 0", busy, sif.s_ready); else passed++;
        total++; if (audio_out !== 8'hAB) $display("FAIL drop_transfer: got %0h want ab", audio_out); else passed++;
        total++; if (underrun_cnt !== 4'd1) $display("FAIL drop_under: got %0d want 1", underrun_cnt); else passed++;
        total++; if (peak_out !== 8'h0F) $display("FAIL drop_peak: got %0h want 0f", peak_out); else passed++;
        @(negedge clk);
        total++; if (audio_out !== 8'd128) $display("FAIL drop_silence: got %0h want 80", audio_out); else passed++;
        enable      = 1'b1;
        sif.s_valid = 1'b0;
        viz_in      = 8'h00;
        @(negedge clk);
        total++; if (busy !== 1'b1) $display("FAIL reen_busy: got %0b want 1", busy); else passed++;
        total++; if (peak_out !== 8'h00) $display("FAIL reen_peak: got %0h want 0", peak_out); else passed++;
        total++; if (underrun_cnt !== 4'd0) $display("FAIL reen_under: got %0d want 0", underrun_cnt); else passed++;
        repeat (4) begin
            total++; if (sif.s_ready !== 1'b0 || underrun_cnt !== 4'd0) $display("FAIL reen_prime: got ready=%0b under=%0d want 0 0", sif.s_ready, underrun_cnt); else passed++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_run();
        go_idle();
        divisor = 16'd1;
        viz_in  = 8'h0F;
        enable  = 1'b1;
        @(negedge clk);
        sif.s_valid = 1'b1;
        sif.s_data  = 8'h55;
        @(negedge clk);
        sif.s_valid = 1'b0;
        repeat (5) @(negedge clk);
        total++; if (peak_out !== 8'h0F) $display("FAIL rstrun_pre_peak: got %0h want 0f", peak_out); else passed++;
        total++; if (underrun_cnt !== 4'd3) $display("FAIL rstrun_pre_under: got %0d want 3", underrun_cnt); else passed++;
        #2;
        rst    = 1'b0;
        enable = 1'b0;
        #1;
        total++; if (sif.s_ready !== 1'b0) $display("FAIL rstrun_ready: got %0b want 0", sif.s_ready); else passed++;
        total++; if (audio_out !== 8'd128) $display("FAIL rstrun_audio: got %0h want 80", audio_out); else passed++;
        total++; if (peak_out !== 8'h00) $display("FAIL rstrun_peak: got %0h want 0", peak_out); else passed++;
        total++; if (irq_clip !== 1'b0) $display("FAIL rstrun_irq: got %0b want 0", irq_clip); else passed++;
        total++; if (underrun_cnt !== 4'd0) $display("FAIL rstrun_under: got %0d want 0", underrun_cnt); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL rstrun_busy: got %0b want 0", busy); else passed++;
        @(negedge clk);
        rst         = 1'b1;
        sif.s_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            total++; if (busy !== 1'b0 || sif.s_ready !== 1'b0 || audio_out !== 8'd128) $display("FAIL rstrun_stay_idle: got busy=%0b ready=%0b audio=%0h want 0 0 80", busy, sif.s_ready, audio_out); else passed++;
        end
    endtask

    initial begin
        rst         = 1'b1;
        enable      = 1'b0;
        divisor     = 16'd0;
        viz_in      = 8'h00;
        sif.s_valid = 1'b0;
        sif.s_data  = 8'h00;
        test_reset();
        test_stream_div3();
        test_random_stream();
        test_underrun_gap();
        test_underrun_saturate();
        test_peak_hold();
        test_peak_random();
        test_enable_drop();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/audio_viz_feeder.md
# audio_viz_feeder

Sample-pacing controller that sits between the audio sample FIFO and the `audio_viz` energy datapath. It pulls 8-bit unsigned samples (centre 128) from a valid/ready stream at a programmable rate and holds each one on the datapath input between ticks, substituting silence (128) on underrun. It also post-processes the datapath's 8-bit thermometer output into a peak-hold/decay level for the LED bar, and raises a clip interrupt when the top bar lights.

## Interface
Parameters:
- `DIV_W`, 16: width of the sample-period divisor.
- `HOLD_TICKS`, 4800: sample ticks a new peak is held before decay starts (100 ms at 48 kHz).
- `UNDERRUN_W`, 16: width of the underrun counter.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  asynchronous, active-low reset.
- `enable`  in  1  run request from the CPU control register.
- `divisor`  in  DIV_W  clocks per sample minus 1; 0 gives one sample per clock.
- `s_valid`  in  1  sample FIFO has data.
- `s_data`  in  8  unsigned sample, centre 128.
- `s_ready`  out  1  sample accepted this cycle.
- `audio_out`  out  8  registered sample to `audio_viz` `audio_in`.
- `viz_in`  in  8  thermometer level from `audio_viz` `viz_out`.
- `peak_out`  out  8  peak-held thermometer level.
- `irq_clip`  out  1  one-cycle pulse on `peak_out[7]` rising.
- `underrun_cnt`  out  UNDERRUN_W  saturating count of ticks with no sample.
- `busy`  out  1  high in PRIME or RUN.

## Operation
- FSM states:
  - IDLE: `s_ready`=0 and `audio_out`=128. Moves to PRIME when `enable`=1. On that entry it clears `peak_out`, `underrun_cnt` and the hold counter.
  - PRIME: `s_ready`=0. Waits for the first `s_valid`, so no startup underruns are counted. When `s_valid`=1 it moves to RUN with the tick counter at 0.
  - RUN: the tick counter counts down. At 0 a tick fires and the counter reloads from `divisor`, which is sampled only at reload.
  - From any state, `enable`=0 moves to IDLE on the next edge. This has priority over all other transitions. Entering IDLE drives `audio_out` to 128.
- Tick in RUN:
  - `s_ready` is 1 combinationally during the tick cycle only.
  - If `s_valid`=1: the transfer occurs and `audio_out` takes `s_data` on the next edge.
  - If `s_valid`=0: `audio_out` takes 128 on the next edge, and `underrun_cnt` increments, saturating at all-ones.
  - Between ticks, `audio_out` holds its value.
- Peak hold, evaluated on each tick only:
  - If `viz_in & ~peak_out` is nonzero: `peak_out` takes `peak_out | viz_in` and the hold counter loads `HOLD_TICKS-1`.
  - Else if the hold counter is 0 and `peak_out` is nonzero: `peak_out` takes `peak_out >> 1` (one bar drops) and the hold counter reloads `HOLD_TICKS-1`.
  - Otherwise the hold counter decrements; it stays at 0 once there.
  - In IDLE and PRIME, `peak_out` is frozen.
- `irq_clip` is 1 for exactly one cycle, the cycle after `peak_out[7]` goes 0->1. It does not pulse again until bit 7 has dropped and risen again.

## Timing
- Reset values (asserted asynchronously): state IDLE, `s_ready` 0, `audio_out` 128, `peak_out` 0, `irq_clip` 0, `underrun_cnt` 0, `busy` 0, tick and hold counters 0.
- Latency from `enable` rise to PRIME is 1 cycle. From `s_valid` seen in PRIME, the first tick (`s_ready`=1) comes 1 cycle later.
- Sample accepted to `audio_out` updated: 1 cycle.
- Tick period is `divisor`+1 clocks. A `divisor` change takes effect after the current period ends.
- `s_data` is sampled only when `s_valid` and `s_ready` are both 1. `s_valid` may drop at any time without penalty except an underrun.
- If `enable` falls in a tick cycle, the tick is still honoured: transfer, `audio_out` update and counting all occur. The state is IDLE on the next edge and `audio_out` is 128 one cycle after that.
- A reset mid-RUN drops any in-flight transfer. Nothing is accepted in the reset cycle.
- `viz_in` is used only on tick edges and needs no synchronisation (same clock).

## Test plan
- `divisor`=3, FIFO always valid with data 0x10,0x20,... -> `s_ready` pulses every 4th clock and `audio_out` steps 0x10,0x20,... one clock after each pulse. `underrun_cnt`=0.
- `divisor`=0 with the FIFO going empty for 5 ticks mid-stream -> `audio_out`=128 during the gap and `underrun_cnt`=5. Stream resumes with no lost samples.
- `UNDERRUN_W`=4, 20 consecutive underruns -> `underrun_cnt` saturates at 15.
- `HOLD_TICKS`=4, `viz_in` 0xFF for 1 tick then 0x00 -> `peak_out`=0xFF and one `irq_clip` pulse. `peak_out` then halves every 4 ticks after a 4-tick hold: 0x7F, 0x3F, ... down to 0x00.
- `enable` dropped in a tick cycle, then raised again -> that tick transfers, `audio_out`=128 within 2 cycles and `busy`=0. On re-enable, `peak_out` and `underrun_cnt` clear and PRIME waits for `s_valid`.
- `rst` asserted mid-RUN with `peak_out`=0x0F -> all outputs go to their reset values immediately (asynchronous). After release, the block stays IDLE until `enable`.
